// File: rtl/ucie_ctl_rx_flow_buffer.sv
// RX flow buffer between the RDI receive path and the FDI interface: circular memory, registered output stage.
// Optional macro UCIE_RX_BUF_DROP_CNT_EN adds a saturating 16-bit dropped-beat counter (o_drop_count).
module ucie_ctl_rx_flow_buffer #(
    parameter int unsigned NBYTES       = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NBYTES*8-1:0]        i_rdi_pl_data,
    input  logic                       i_rdi_pl_valid,
    input  logic                       i_buffer_en,
    input  logic                       i_fdi_ready,
    input  logic                       i_overflow_clr,
    output logic [NBYTES*8-1:0]        o_fdi_data,
    output logic                       o_fdi_data_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_almost_full,
    output logic                       o_full,
    output logic                       o_empty,
`ifdef UCIE_RX_BUF_DROP_CNT_EN
    output logic                       o_overflow_detected,
    output logic [15:0]                o_drop_count
`else
    output logic                       o_overflow_detected
`endif
);

    localparam int unsigned DW = NBYTES * 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [DW-1:0] out_data_r;
    logic          out_valid_r;
    logic          afull_r;
    logic          full_r;
    logic          empty_r;
    logic          ovf_r;
    logic          pop_s;
    logic          wr_req_s;
    logic          wr_s;
    logic          drop_s;

    // Handshake decode; a beat arriving during reset is never written
    always_comb begin
        pop_s    = 1'b0;
        wr_req_s = 1'b0;
        wr_s     = 1'b0;
        drop_s   = 1'b0;
        if (i_rst) begin
            pop_s    = 1'b0;
            wr_req_s = 1'b0;
        end else begin
            pop_s    = i_buffer_en && !empty_r && (!out_valid_r || i_fdi_ready);
            wr_req_s = i_buffer_en && i_rdi_pl_valid;
        end
        if (wr_req_s && (!full_r || pop_s)) begin
            wr_s = 1'b1;
        end else begin
            wr_s = 1'b0;
        end
        if (wr_req_s && full_r && !pop_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Next occupancy, so the registered flags line up with o_count in the same cycle
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; intentionally not reset
    always_ff @(posedge i_clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= i_rdi_pl_data;
        end
    end

    // Pointers, occupancy, flags, output stage and sticky overflow
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            afull_r     <= 1'b0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_nxt_s;
            afull_r <= (count_nxt_s >= CW'(AFULL_THRESH));
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == CW'(0));
            // Output stage: load on pop, otherwise release once the sink takes the beat
            if (pop_s) begin
                out_data_r  <= mem_r[rd_ptr_r];
                out_valid_r <= 1'b1;
            end else if (out_valid_r && i_fdi_ready) begin
                out_valid_r <= 1'b0;
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (i_overflow_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

`ifdef UCIE_RX_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating drop counter; a coincident drop and clear leaves exactly one
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && i_overflow_clr) begin
            drop_cnt_r <= 16'h0001;
        end else if (i_overflow_clr) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    assign o_drop_count = drop_cnt_r;
`endif

    assign o_fdi_data          = out_data_r;
    assign o_fdi_data_valid    = out_valid_r;
    assign o_count             = count_r;
    assign o_almost_full       = afull_r;
    assign o_full              = full_r;
    assign o_empty             = empty_r;
    assign o_overflow_detected = ovf_r;

endmodule

// File: tb/tb_ucie_ctl_rx_flow_buffer.sv
// Table-driven bench for ucie_ctl_rx_flow_buffer (DEPTH=16, AFULL_THRESH=14), plus a hand-written overflow/clear sequence.
module tb_ucie_ctl_rx_flow_buffer;

    logic        clk;
    logic        rst;
    logic [63:0] rdi_data;
    logic        rdi_valid;
    logic        buf_en;
    logic        fdi_ready;
    logic        ovf_clr;
    logic [63:0] fdi_data;
    logic        fdi_valid;
    logic [4:0]  count;
    logic        almost_full;
    logic        full;
    logic        empty;
    logic        ovf;
`ifdef UCIE_RX_BUF_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int tests  = 0;
    int failed = 0;

    ucie_ctl_rx_flow_buffer #(.NBYTES(8), .DEPTH(16), .AFULL_THRESH(14)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_rdi_pl_data       (rdi_data),
        .i_rdi_pl_valid      (rdi_valid),
        .i_buffer_en         (buf_en),
        .i_fdi_ready         (fdi_ready),
        .i_overflow_clr      (ovf_clr),
        .o_fdi_data          (fdi_data),
        .o_fdi_data_valid    (fdi_valid),
        .o_count             (count),
        .o_almost_full       (almost_full),
        .o_full              (full),
        .o_empty             (empty),
`ifdef UCIE_RX_BUF_DROP_CNT_EN
        .o_overflow_detected (ovf),
        .o_drop_count        (drop_count)
`else
        .o_overflow_detected (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic en;
        logic vld;
        int   data;
        logic rdy;
        logic clr;
        logic exp_valid;
        int   exp_data;
        int   exp_count;
        logic exp_ovf;
        int   exp_drops;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic v, input int d, input logic rd,
                       input logic c, input logic ev, input int ed, input int ec, input logic eo,
                       input int edr);
        vec_t x;
        x.rst = r; x.en = e; x.vld = v; x.data = d; x.rdy = rd; x.clr = c;
        x.exp_valid = ev; x.exp_data = ed; x.exp_count = ec; x.exp_ovf = eo; x.exp_drops = edr;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then check outputs just after the rising edge
    task automatic apply(input vec_t x, input int idx);
        @(negedge clk);
        rst       = x.rst;
        buf_en    = x.en;
        rdi_valid = x.vld;
        rdi_data  = 64'(x.data);
        fdi_ready = x.rdy;
        ovf_clr   = x.clr;
        @(posedge clk);
        #1;
        chk("valid", idx, int'(fdi_valid), int'(x.exp_valid));
        chk("data",  idx, int'(fdi_data[31:0]), x.exp_data);
        chk("count", idx, int'(count), x.exp_count);
        chk("empty", idx, int'(empty), int'(x.exp_count == 0));
        chk("full",  idx, int'(full), int'(x.exp_count == 16));
        chk("afull", idx, int'(almost_full), int'(x.exp_count >= 14));
        chk("ovf",   idx, int'(ovf), int'(x.exp_ovf));
`ifdef UCIE_RX_BUF_DROP_CNT_EN
        chk("drops", idx, int'(drop_count), x.exp_drops);
`endif
    endtask

    initial begin
        vec_t h;
        rst = 1'b1; buf_en = 1'b0; rdi_valid = 1'b0; rdi_data = 64'd0;
        fdi_ready = 1'b0; ovf_clr = 1'b0;

        // Reset held two cycles
        add(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        add(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        // Streaming 0x01..0x20, one-cycle latency
        for (int i = 1; i <= 32; i++)
            add(1'b0, 1'b1, 1'b1, i, 1'b1, 1'b0, i > 1, (i > 1) ? i - 1 : 0, 1, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 32, 0, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 32, 0, 1'b0, 0);
        // Fill with sink stalled: beat 1 in output stage, 2..17 in memory, 18 dropped
        for (int k = 1; k <= 18; k++)
            add(1'b0, 1'b1, 1'b1, 'h40 + k, 1'b0, 1'b0, k >= 2, (k >= 2) ? 'h41 : 32,
                (k == 1) ? 1 : ((k <= 17) ? k - 1 : 16), k == 18, (k == 18) ? 1 : 0);
        // Drain across the pointer wrap
        for (int j = 1; j <= 16; j++)
            add(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 'h41 + j, 16 - j, 1'b1, 1);
        add(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 'h51, 0, 1'b1, 1);
        add(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 'h51, 0, 1'b0, 0);
        // Reset with a beat presented, then fill and write-while-full with pop
        add(1'b1, 1'b1, 1'b1, 'h99, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        for (int k = 1; k <= 17; k++)
            add(1'b0, 1'b1, 1'b1, 'h60 + k, 1'b0, 1'b0, k >= 2, (k >= 2) ? 'h61 : 0,
                (k == 1) ? 1 : k - 1, 1'b0, 0);
        add(1'b0, 1'b1, 1'b1, 'h72, 1'b1, 1'b0, 1'b1, 'h62, 16, 1'b0, 0);
        // Mid-operation reset discards everything; the reset-cycle beat is not stored
        add(1'b1, 1'b1, 1'b1, 'h99, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        // Enable low with five beats stored
        for (int k = 1; k <= 6; k++)
            add(1'b0, 1'b1, 1'b1, 'h80 + k, 1'b0, 1'b0, k >= 2, (k >= 2) ? 'h81 : 0,
                (k == 1) ? 1 : k - 1, 1'b0, 0);
        add(1'b0, 1'b0, 1'b1, 'hEE, 1'b1, 1'b0, 1'b0, 'h81, 5, 1'b0, 0);
        add(1'b0, 1'b0, 1'b1, 'hEE, 1'b1, 1'b0, 1'b0, 'h81, 5, 1'b0, 0);
        for (int j = 1; j <= 5; j++)
            add(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 'h81 + j, 5 - j, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 'h86, 0, 1'b0, 0);

        for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);

        // Hand sequence: repeated drops, drop coinciding with clear, then enable-low writes while full
        for (int k = 1; k <= 17; k++) begin
            h.rst = 1'b0; h.en = 1'b1; h.vld = 1'b1; h.data = 'hA0 + k; h.rdy = 1'b0; h.clr = 1'b0;
            h.exp_valid = (k >= 2); h.exp_data = (k >= 2) ? 'hA1 : 'h86;
            h.exp_count = (k == 1) ? 1 : k - 1; h.exp_ovf = 1'b0; h.exp_drops = 0;
            apply(h, 1000 + k);
        end
        h.data = 'hB2; h.exp_valid = 1'b1; h.exp_data = 'hA1; h.exp_count = 16;
        h.exp_ovf = 1'b1; h.exp_drops = 1;
        apply(h, 1018);
        h.data = 'hB3; h.exp_drops = 2;
        apply(h, 1019);
        h.data = 'hB4; h.clr = 1'b1; h.exp_ovf = 1'b1; h.exp_drops = 1;
        apply(h, 1020);
        h.vld = 1'b0; h.clr = 1'b1; h.exp_ovf = 1'b0; h.exp_drops = 0;
        apply(h, 1021);
        h.en = 1'b0; h.vld = 1'b1; h.clr = 1'b0; h.exp_ovf = 1'b0; h.exp_drops = 0;
        apply(h, 1022);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
